// File: rtl/mem_pkg.sv
// Shared encodings for the memory burst master: burst size codes, controller
// states and the size-to-beat-count mapping.
package mem_pkg;

   localparam logic [1:0] ACCESS_1W  = 2'b00;
   localparam logic [1:0] ACCESS_4W  = 2'b01;
   localparam logic [1:0] ACCESS_8W  = 2'b10;
   localparam logic [1:0] ACCESS_16W = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_RD_BEATS,
      ST_WR_BEATS,
      ST_DONE
   } state_t;

   function automatic logic [4:0] beats(input logic [1:0] size);
      logic [4:0] n;
      case (size)
         ACCESS_1W:  n = 5'd1;
         ACCESS_4W:  n = 5'd4;
         ACCESS_8W:  n = 5'd8;
         ACCESS_16W: n = 5'd16;
         default:    n = 5'd1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/mem_beat_counter.sv
// Beat index within a burst: cleared at transaction start, advanced once per
// transferred beat, flags the final beat of the current burst.
module mem_beat_counter #(
   parameter int CW = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clear,
   input  logic          inc,
   input  logic [CW-1:0] last_idx,
   output logic          last
);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (inc) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign last = (count_reg == last_idx);

endmodule

// File: rtl/mem_burst_master.sv
// Memory port initiator: accepts one client request at a time, issues the
// memory start strobe, streams write beats out and read beats back.
module mem_burst_master
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MAX_BEATS  = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_rw,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0]            req_size,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_ready,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_last,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   output logic [1:0]            mem_access_size,
   output logic                  mem_rw,
   output logic                  mem_enable,
   input  logic                  mem_busy,
   input  logic [DATA_WIDTH-1:0] mem_data_out
);

   localparam int CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [1:0]            size_reg;
   logic                  rw_reg;
   logic                  err_reg;
   logic                  cnt_clear;
   logic                  cnt_inc;
   logic                  cnt_last;
   logic [CW-1:0]         last_idx;
   logic                  misaligned;

   assign misaligned      = (req_addr[1:0] != 2'b00);
   assign last_idx        = CW'(beats(size_reg) - 5'd1);
   assign mem_address     = addr_reg;
   assign mem_access_size = size_reg;
   assign mem_rw          = rw_reg;

   mem_beat_counter #(
      .CW(CW)
   ) u_beat_counter (
      .clock    (clock),
      .reset    (reset),
      .clear    (cnt_clear),
      .inc      (cnt_inc),
      .last_idx (last_idx),
      .last     (cnt_last)
   );

   // Request fields are only latched for aligned requests; a rejected one
   // just records the error flag for the DONE response.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         addr_reg  <= '0;
         size_reg  <= ACCESS_1W;
         rw_reg    <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (req_ready) begin
            err_reg <= misaligned;
            if (!misaligned) begin
               addr_reg <= req_addr;
               size_reg <= req_size;
               rw_reg   <= req_rw;
            end
         end
      end
   end

   // Handshake outputs are suppressed while reset is high so an abort takes
   // effect in the same cycle reset is raised.
   always_comb begin
      state_next  = state_reg;
      req_ready   = 1'b0;
      wr_ready    = 1'b0;
      rsp_valid   = 1'b0;
      rsp_data    = '0;
      rsp_last    = 1'b0;
      rsp_err     = 1'b0;
      mem_enable  = 1'b0;
      mem_data_in = '0;
      cnt_clear   = 1'b0;
      cnt_inc     = 1'b0;
      if (!reset) begin
         case (state_reg)
            ST_IDLE: begin
               req_ready = req_valid;
               if (req_valid) begin
                  cnt_clear  = 1'b1;
                  state_next = misaligned ? ST_DONE : ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (!mem_busy) begin
                  mem_enable = 1'b1;
                  if (rw_reg) begin
                     // Beat 0 of a write travels with the start strobe.
                     wr_ready    = 1'b1;
                     mem_data_in = wr_data;
                     cnt_inc     = !cnt_last;
                     state_next  = cnt_last ? ST_DONE : ST_WR_BEATS;
                  end else begin
                     state_next = ST_RD_BEATS;
                  end
               end
            end
            ST_RD_BEATS: begin
               rsp_valid = 1'b1;
               rsp_data  = mem_data_out;
               rsp_last  = cnt_last;
               cnt_inc   = !cnt_last;
               if (cnt_last) begin
                  state_next = ST_IDLE;
               end
            end
            ST_WR_BEATS: begin
               wr_ready    = 1'b1;
               mem_data_in = wr_data;
               cnt_inc     = !cnt_last;
               if (cnt_last) begin
                  state_next = ST_DONE;
               end
            end
            ST_DONE: begin
               rsp_valid  = 1'b1;
               rsp_last   = 1'b1;
               rsp_err    = err_reg;
               state_next = ST_IDLE;
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_burst_master.sv
// Randomised scoreboard bench for mem_burst_master with a word-array memory
// model, a write-data client and a response monitor.
module tb_mem_burst_master;

   localparam int DW        = 32;
   localparam int AW        = 32;
   localparam int MEM_WORDS = 1024;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_rw = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [1:0]    req_size = 2'b00;
   logic [DW-1:0] wr_data = '0;
   logic          wr_ready;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          rsp_last;
   logic          rsp_err;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_data_in;
   logic [1:0]    mem_access_size;
   logic          mem_rw;
   logic          mem_enable;
   logic          mem_busy = 1'b0;
   logic [DW-1:0] mem_data_out = '0;

   always #5 clock = ~clock;

   mem_burst_master #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .MAX_BEATS (16)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_rw          (req_rw),
      .req_addr        (req_addr),
      .req_size        (req_size),
      .wr_data         (wr_data),
      .wr_ready        (wr_ready),
      .rsp_valid       (rsp_valid),
      .rsp_data        (rsp_data),
      .rsp_last        (rsp_last),
      .rsp_err         (rsp_err),
      .mem_address     (mem_address),
      .mem_data_in     (mem_data_in),
      .mem_access_size (mem_access_size),
      .mem_rw          (mem_rw),
      .mem_enable      (mem_enable),
      .mem_busy        (mem_busy),
      .mem_data_out    (mem_data_out)
   );

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic        err;
   } rsp_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        rw;
      logic [1:0]  size;
   } start_t;

   int          total = 0;
   int          bad = 0;
   int          rsp_seen = 0;
   rsp_t        rsp_q[$];
   start_t      start_q[$];
   logic [31:0] wr_q[$];
   logic [31:0] mem_arr[MEM_WORDS];
   logic [31:0] ref_mem[MEM_WORDS];

   function automatic int nbeats(input logic [1:0] size);
      return (size == 2'b00) ? 1 : (2 << size);
   endfunction

   function automatic logic [31:0] init_word(input int i);
      if (i == 32'h40) return 32'hDEADBEEF;
      return (i * 32'h9E3779B9) ^ 32'h5A5A0000;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Response monitor.
   always @(negedge clock) begin
      rsp_t e;
      if (rsp_valid) begin
         rsp_seen++;
         if (rsp_q.size() == 0) begin
            chk("rsp_unexpected", 64'd1, 64'd0);
         end else begin
            e = rsp_q.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_last", rsp_last, e.last);
            chk("rsp_err", rsp_err, e.err);
         end
      end
   end

   // Write-data client: consumes a beat whenever wr_ready is high.
   always @(negedge clock) begin
      if (wr_ready) begin
         if (wr_q.size() == 0) begin
            chk("wr_unexpected", 64'd1, 64'd0);
         end else begin
            chk("mem_data_in", mem_data_in, wr_q[0]);
            void'(wr_q.pop_front());
         end
      end
      #1;
      wr_data = (wr_q.size() != 0) ? wr_q[0] : 32'h0;
   end

   // Memory model: start strobe check, write capture, read beat k at start+1+k.
   initial begin
      start_t st;
      int     rd_left;
      int     rd_idx;
      int     wr_left;
      int     wr_idx;
      int     base;
      rd_left = 0;
      rd_idx  = 0;
      wr_left = 0;
      wr_idx  = 0;
      for (int i = 0; i < MEM_WORDS; i++) mem_arr[i] = init_word(i);
      forever begin
         @(negedge clock);
         if (mem_enable) begin
            if (mem_busy) chk("enable_while_busy", 64'd1, 64'd0);
            if (start_q.size() == 0) begin
               chk("start_unexpected", 64'd1, 64'd0);
            end else begin
               st = start_q.pop_front();
               chk("mem_address", mem_address, st.addr);
               chk("mem_rw", mem_rw, st.rw);
               chk("mem_access_size", mem_access_size, st.size);
            end
            base = int'(mem_address >> 2) % MEM_WORDS;
            if (mem_rw) begin
               mem_arr[base] = mem_data_in;
               wr_idx  = (base + 1) % MEM_WORDS;
               wr_left = nbeats(mem_access_size) - 1;
            end else begin
               rd_idx  = base;
               rd_left = nbeats(mem_access_size);
            end
         end else if (wr_left > 0) begin
            mem_arr[wr_idx] = mem_data_in;
            wr_idx  = (wr_idx + 1) % MEM_WORDS;
            wr_left--;
         end
         #1;
         if (rd_left > 0) begin
            mem_data_out = mem_arr[rd_idx];
            rd_idx  = (rd_idx + 1) % MEM_WORDS;
            rd_left--;
         end else begin
            mem_data_out = 32'h0;
         end
      end
   end

   task automatic issue_req(input logic rw, input logic [31:0] addr, input logic [1:0] size,
                            input int busy, input bit counting_data);
      int          n;
      int          idx;
      logic [31:0] d;
      int          t;
      n   = nbeats(size);
      idx = int'(addr >> 2);
      if (addr[1:0] != 2'b00) begin
         rsp_q.push_back('{data: 32'h0, last: 1'b1, err: 1'b1});
      end else begin
         start_q.push_back('{addr: addr, rw: rw, size: size});
         if (rw) begin
            for (int k = 0; k < n; k++) begin
               d = counting_data ? 32'(k + 1) : $urandom;
               wr_q.push_back(d);
               ref_mem[idx + k] = d;
            end
            rsp_q.push_back('{data: 32'h0, last: 1'b1, err: 1'b0});
         end else begin
            for (int k = 0; k < n; k++)
               rsp_q.push_back('{data: ref_mem[idx + k], last: (k == n - 1), err: 1'b0});
         end
      end
      mem_busy  = (busy > 0);
      req_valid = 1'b1;
      req_rw    = rw;
      req_addr  = addr;
      req_size  = size;
      for (t = 0; t < 50; t++) begin
         @(negedge clock);
         if (req_ready) break;
      end
      if (t == 50) chk("accept_timeout", 64'd1, 64'd0);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      if (busy > 0) begin
         repeat (busy) @(posedge clock);
         #1;
         mem_busy = 1'b0;
      end
   endtask

   task automatic wait_done(input logic rw, input logic [31:0] addr, input logic [1:0] size,
                            input int busy);
      int t;
      for (t = 0; t < 200; t++) begin
         @(negedge clock);
         #1;
         if (rsp_q.size() == 0) break;
      end
      if (t == 200) chk("done_timeout", 64'd1, 64'd0);
      chk("starts_left", start_q.size(), 64'd0);
      chk("wr_beats_left", wr_q.size(), 64'd0);
      $display("txn rw=%0d addr=%08h size=%0d busy=%0d", rw, addr, size, busy);
      @(posedge clock);
      #1;
   endtask

   task automatic do_req(input logic rw, input logic [31:0] addr, input logic [1:0] size,
                         input int busy, input bit counting_data);
      issue_req(rw, addr, size, busy, counting_data);
      wait_done(rw, addr, size, busy);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, req_ready, 64'd0);
      chk({tag, "_wr_ready"}, wr_ready, 64'd0);
      chk({tag, "_rsp_valid"}, rsp_valid, 64'd0);
      chk({tag, "_rsp_last"}, rsp_last, 64'd0);
      chk({tag, "_rsp_err"}, rsp_err, 64'd0);
      chk({tag, "_rsp_data"}, rsp_data, 64'd0);
      chk({tag, "_mem_enable"}, mem_enable, 64'd0);
      chk({tag, "_mem_rw"}, mem_rw, 64'd0);
      chk({tag, "_mem_address"}, mem_address, 64'd0);
      chk({tag, "_mem_data_in"}, mem_data_in, 64'd0);
      chk({tag, "_mem_access_size"}, mem_access_size, 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int          seen0;
      int          t;
      logic        rw;
      logic [1:0]  size;
      logic [31:0] addr;
      int          busy;
      for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);

      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check_reset_outputs("reset");

      @(posedge clock);
      #1;
      do_req(1'b0, 32'h100, 2'b00, 0, 1'b0);
      do_req(1'b0, 32'h40, 2'b11, 0, 1'b0);
      do_req(1'b1, 32'h200, 2'b01, 0, 1'b1);
      for (int k = 0; k < 4; k++) chk("wr_mem_word", mem_arr[32'h80 + k], 64'(k + 1));
      do_req(1'b0, 32'h200, 2'b01, 0, 1'b0);
      do_req(1'b0, 32'h180, 2'b10, 5, 1'b0);
      do_req(1'b1, 32'h240, 2'b00, 5, 1'b0);
      do_req(1'b0, 32'h102, 2'b01, 0, 1'b0);
      do_req(1'b1, 32'h301, 2'b11, 0, 1'b0);

      // Reset on beat 3 of an 8-beat read.
      seen0 = rsp_seen;
      issue_req(1'b0, 32'h300, 2'b10, 0, 1'b0);
      for (t = 0; t < 50; t++) begin
         @(negedge clock);
         #1;
         if (rsp_seen - seen0 >= 3) break;
      end
      if (t == 50) chk("beat3_timeout", 64'd1, 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      rsp_q.delete();
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check_reset_outputs("abort");
      repeat (12) @(posedge clock);
      #1;
      chk("abort_starts_left", start_q.size(), 64'd0);
      $display("txn rw=0 addr=00000300 size=2 aborted by reset");

      for (int r = 0; r < 40; r++) begin
         rw   = 1'($urandom_range(0, 1));
         size = 2'($urandom_range(0, 3));
         addr = 32'($urandom_range(0, MEM_WORDS - 16)) << 2;
         if ($urandom_range(0, 7) == 0) addr = addr | 32'($urandom_range(1, 3));
         busy = $urandom_range(0, 3);
         do_req(rw, addr, size, busy, 1'b0);
      end

      for (int i = 0; i < MEM_WORDS; i++) begin
         if (mem_arr[i] !== ref_mem[i]) chk("final_mem", mem_arr[i], ref_mem[i]);
      end
      chk("final_mem_sample", mem_arr[32'h80], ref_mem[32'h80]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
